// File: rtl/axis_demux1_n.sv
// rtl/axis_demux1_n.sv - packet-aware AXI4-Stream 1-to-N demultiplexer with output register slice
//
// The route is picked from sel on the first beat of each frame and stays locked
// until that frame's tlast beat is accepted. Frames whose sel is not a real channel
// are swallowed. Output goes through a main + skid register pair, so the block
// keeps 1 beat/cycle under continuous ready.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   sel               destination channel, sampled on the first beat of a frame
//   s_axis_*          slave stream (tdata/tvalid/tlast in, tready out)
//   m_axis_tdata      channel k on bits [k*width +: width]; 0 on idle channels
//   m_axis_tvalid/tlast/tready  one bit per channel
//   busy              route locked (frame in progress, routed or dropped)
//   drop_pulse        one cycle after the first beat of an out-of-range frame is taken
module axis_demux1_n #(
  parameter int width     = 8,
  parameter int channels  = 4,
  parameter int sel_width = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [sel_width-1:0]        sel,
  input  logic [width-1:0]            s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [width*channels-1:0]   m_axis_tdata,
  output logic [channels-1:0]         m_axis_tvalid,
  output logic [channels-1:0]         m_axis_tlast,
  input  logic [channels-1:0]         m_axis_tready,
  output logic                        busy,
  output logic                        drop_pulse
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]           state;
  logic [sel_width-1:0] route_dest;

  logic                 main_valid;
  logic [width-1:0]     main_data;
  logic                 main_last;
  logic [sel_width-1:0] main_dest;

  logic                 skid_valid;
  logic [width-1:0]     skid_data;
  logic                 skid_last;
  logic [sel_width-1:0] skid_dest;

  logic                 sel_oor;
  logic                 in_acc;
  logic                 drop_beat;
  logic                 to_slice;
  logic [sel_width-1:0] beat_dest;
  logic                 main_ready;
  logic                 main_drain;

  // Zero-extend before comparing so sel wider or narrower than channels behaves.
  assign sel_oor = 32'(sel) >= 32'(channels);

  // DROP never touches the slice, so it can always accept. Reset forces ready low
  // directly, so it is already 0 while rst is held and 1 as soon as it releases.
  assign s_axis_tready = !rst && ((state == DROP) || !skid_valid);
  assign in_acc        = s_axis_tvalid && s_axis_tready;

  assign drop_beat = (state == DROP) || ((state == IDLE) && sel_oor);
  assign to_slice  = in_acc && !drop_beat;
  assign beat_dest = (state == ROUTE) ? route_dest : sel;

  assign busy = (state != IDLE);

  // Only the ready bit of the channel the main beat belongs to can drain it.
  always_comb begin
    main_ready = 1'b0;
    for (int k = 0; k < channels; k++) begin
      if (32'(main_dest) == k) begin
        main_ready = m_axis_tready[k];
      end
    end
  end

  assign main_drain = main_valid && main_ready;

  always_comb begin
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    m_axis_tdata  = '0;
    for (int k = 0; k < channels; k++) begin
      if (main_valid && (32'(main_dest) == k)) begin
        m_axis_tvalid[k]               = 1'b1;
        m_axis_tlast[k]                = main_last;
        m_axis_tdata[k*width +: width] = main_data;
      end
    end
  end

  // Route FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      route_dest <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= in_acc && (state == IDLE) && sel_oor;
      if (in_acc) begin
        case (state)
          IDLE: begin
            if (!s_axis_tlast) begin
              state      <= sel_oor ? DROP : ROUTE;
              route_dest <= sel;
            end
          end
          ROUTE, DROP: begin
            if (s_axis_tlast) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Register slice: skid only fills when main is stalled, and the skid full
  // flag is what throttles the input, so at most one beat lands per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_last  <= 1'b0;
      main_dest  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_dest  <= '0;
    end else begin
      if (!main_valid || main_drain) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          main_last  <= skid_last;
          main_dest  <= skid_dest;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= to_slice;
          if (to_slice) begin
            main_data <= s_axis_tdata;
            main_last <= s_axis_tlast;
            main_dest <= beat_dest;
          end
        end
      end else if (to_slice) begin
        skid_valid <= 1'b1;
        skid_data  <= s_axis_tdata;
        skid_last  <= s_axis_tlast;
        skid_dest  <= beat_dest;
      end
    end
  end

endmodule

// File: tb/tb_axis_demux1_n.sv
// tb/tb_axis_demux1_n.sv - randomized, model-checked bench for axis_demux1_n
module tb_axis_demux1_n;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SW-1:0]     sel = '0;
  logic [W-1:0]      s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [W*CH-1:0]   m_axis_tdata;
  logic [CH-1:0]     m_axis_tvalid;
  logic [CH-1:0]     m_axis_tlast;
  logic [CH-1:0]     m_axis_tready = '1;
  logic              busy;
  logic              drop_pulse;

  axis_demux1_n #(.width(W), .channels(CH), .sel_width(SW)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every beat that should reach the outputs, oldest first.
  typedef struct {
    int       dest;
    logic [7:0] data;
    logic     last;
  } beat_t;

  beat_t q[$];
  bit    in_frame   = 0;
  bit    frame_drop = 0;
  int    frame_dest = 0;
  bit    exp_drop   = 0;

  // Checks the outputs, then applies what the coming rising edge will do.
  always @(negedge clk) begin
    logic [CH-1:0]   ev, el;
    logic [W*CH-1:0] ed;
    bit acc, drain, drp, oor;
    int d;
    if (rst) begin
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tlast",  32'(m_axis_tlast), 0);
      chk("rst_tdata",  32'(m_axis_tdata), 0);
      chk("rst_ready",  32'(s_axis_tready), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_drop",   32'(drop_pulse), 0);
      q.delete();
      in_frame = 0;
      exp_drop = 0;
    end else begin
      ev = '0; el = '0; ed = '0;
      if (q.size() > 0) begin
        ev[q[0].dest] = 1'b1;
        el[q[0].dest] = q[0].last;
        ed[q[0].dest*W +: W] = q[0].data;
      end
      chk("tvalid", 32'(m_axis_tvalid), 32'(ev));
      chk("tlast",  32'(m_axis_tlast), 32'(el));
      chk("tdata",  32'(m_axis_tdata), 32'(ed));
      chk("busy",   32'(busy), 32'(in_frame));
      chk("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
      chk("s_tready", 32'(s_axis_tready),
          (in_frame && frame_drop) ? 1 : 32'(q.size() < 2));

      drain = (q.size() > 0) && m_axis_tready[q[0].dest];
      acc   = s_axis_tvalid && s_axis_tready;
      if (drain) void'(q.pop_front());
      exp_drop = 0;
      if (acc) begin
        if (!in_frame) begin
          d   = int'(sel);
          oor = d >= CH;
          drp = oor;
          exp_drop = oor;
          if (!s_axis_tlast) begin
            in_frame   = 1;
            frame_drop = oor;
            frame_dest = d;
          end
        end else begin
          d   = frame_dest;
          drp = frame_drop;
          if (s_axis_tlast) in_frame = 0;
        end
        if (!drp) q.push_back('{dest: d, data: s_axis_tdata, last: s_axis_tlast});
      end
    end
  end

  bit rand_rdy = 0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 m_axis_tready = CH'($urandom);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is taken.
  task automatic send_beat(input logic [SW-1:0] s, input logic [7:0] d, input logic l);
    int n = 0;
    sel = s; s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    #0 chk("ready_after_release", 32'(s_axis_tready), 1);
    idle(1);

    // Frame routing: sel changes mid-frame, all beats stay on channel 2.
    send_beat(2'd2, 8'h11, 1'b0);
    chk("route_first_valid", 32'(m_axis_tvalid), 32'b100);
    chk("route_first_data", 32'(m_axis_tdata), 32'h110000);
    chk("route_busy", 32'(busy), 1);
    send_beat(2'd1, 8'h22, 1'b0);
    chk("route_sel_ignored", 32'(m_axis_tvalid), 32'b100);
    send_beat(2'd1, 8'h33, 1'b0);
    send_beat(2'd1, 8'h44, 1'b1);
    chk("route_last_data", 32'(m_axis_tdata), 32'h440000);
    chk("route_last_flag", 32'(m_axis_tlast), 32'b100);
    chk("route_busy_clear", 32'(busy), 0);
    idle(2);

    // Back-to-back single-beat frames to different channels.
    send_beat(2'd0, 8'hA5, 1'b1);
    chk("b2b_ch0", 32'(m_axis_tvalid), 32'b001);
    chk("b2b_ch0_data", 32'(m_axis_tdata), 32'h0000A5);
    send_beat(2'd2, 8'h5A, 1'b1);
    chk("b2b_ch2", 32'(m_axis_tvalid), 32'b100);
    chk("b2b_ch2_data", 32'(m_axis_tdata), 32'h5A0000);
    chk("b2b_ready", 32'(s_axis_tready), 1);
    idle(2);

    // Backpressure: channel 1 stalled, skid fills, input throttles.
    m_axis_tready = 3'b101;
    send_beat(2'd1, 8'hB1, 1'b0);
    send_beat(2'd1, 8'hB2, 1'b0);
    chk("skid_full_ready", 32'(s_axis_tready), 0);
    chk("skid_head", 32'(m_axis_tdata), 32'h00B100);
    idle(3);
    m_axis_tready = 3'b111;
    send_beat(2'd1, 8'hB3, 1'b0);
    send_beat(2'd1, 8'hB4, 1'b0);
    send_beat(2'd1, 8'hB5, 1'b1);
    idle(4);

    // Drop: sel=3 does not exist with three channels.
    send_beat(2'd3, 8'hD1, 1'b0);
    chk("drop_pulse_hi", 32'(drop_pulse), 1);
    chk("drop_no_valid", 32'(m_axis_tvalid), 0);
    chk("drop_busy", 32'(busy), 1);
    send_beat(2'd0, 8'hD2, 1'b0);
    chk("drop_pulse_lo", 32'(drop_pulse), 0);
    send_beat(2'd0, 8'hD3, 1'b1);
    chk("drop_still_none", 32'(m_axis_tvalid), 0);
    send_beat(2'd0, 8'hE0, 1'b1);
    chk("after_drop_ch0", 32'(m_axis_tvalid), 32'b001);
    idle(2);

    // Reset mid-frame with beats parked in the slice.
    m_axis_tready = 3'b000;
    send_beat(2'd1, 8'hC1, 1'b0);
    send_beat(2'd1, 8'hC2, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(m_axis_tvalid), 0);
    chk("midrst_busy", 32'(busy), 0);
    idle(2);
    rst = 1'b0;
    m_axis_tready = 3'b111;
    idle(1);
    send_beat(2'd0, 8'h77, 1'b1);
    chk("post_rst_ch0", 32'(m_axis_tvalid), 32'b001);
    chk("post_rst_data", 32'(m_axis_tdata), 32'h000077);
    idle(2);

    // Random frames, random sel (including out of range), random backpressure.
    rand_rdy = 1;
    for (int f = 0; f < 300; f++) begin
      int len;
      logic [SW-1:0] fs;
      len = $urandom_range(1, 5);
      fs  = SW'($urandom);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat((b == 0) ? fs : SW'($urandom), 8'($urandom), b == len - 1);
      end
    end
    rand_rdy = 0;
    idle(1);
    m_axis_tready = '1;
    idle(6);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    chk("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_demux1_n.md
Name: axis_demux1_n

Overview:
- Packet-aware AXI4-Stream 1-to-N demultiplexer; successor to the fixed 2-way demux.
- Routing is chosen from `sel` on the first beat of each frame and held until that frame's `tlast` beat is accepted, so frames are never split across outputs.
- Output passes through a full-throughput register slice (main register plus skid register).
- Frames addressed to a non-existent channel are consumed and discarded.
- Sits between a stream source and N downstream processing channels.

Parameters:
- width, 8, tdata width in bits (>=1)
- channels, 4, number of master outputs (2..16)
- sel_width, 2, width of sel; must satisfy 2**sel_width >= channels

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sel  in  sel_width  destination channel index; sampled only on the first beat of a frame
- s_axis_tdata  in  width  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input end-of-frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  width*channels  channel k occupies bits [k*width +: width]
- m_axis_tvalid  out  channels  per-channel valid
- m_axis_tlast  out  channels  per-channel end-of-frame
- m_axis_tready  in  channels  per-channel ready
- busy  out  1  high while a frame is in progress (route locked)
- drop_pulse  out  1  one-cycle pulse when a frame with out-of-range sel begins

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state (`rst=1`, immediate):
  - all `m_axis_*` outputs are 0; `s_axis_tready`, `busy` and `drop_pulse` are 0;
  - main and skid registers are empty; route is unlocked.
  - The first cycle after reset release has `s_axis_tready=1`.
- Handshake: a beat transfers when `valid && ready` on a rising edge.
- Route FSM states:
  - IDLE (unlocked):
    - the accepted beat's destination is the current `sel`;
    - if `sel < channels` and `tlast=0` -> ROUTE (dest latched);
    - if `sel >= channels` and `tlast=0` -> DROP;
    - single-beat frames (`tlast=1`) remain in IDLE;
    - `drop_pulse=1` on the cycle after any out-of-range first beat is accepted, including single-beat frames.
  - ROUTE: every accepted beat goes to the latched dest; `sel` is ignored. The accepted beat with `tlast=1` -> IDLE.
  - DROP: `s_axis_tready=1` unconditionally; beats are discarded and never reach the slice. The accepted beat with `tlast=1` -> IDLE.
  - `busy=1` in ROUTE and DROP.
- Register slice (IDLE and ROUTE):
  - `s_axis_tready = !skid_full`.
  - An accepted beat loads the main register if it is empty or being drained in the same cycle; otherwise it loads the skid register.
  - When main drains and skid is full, skid moves to main.
  - Latency from input accept to output valid is 1 cycle.
  - Sustains 1 beat/cycle with `tready` held high.
  - Only the dest's `tvalid`/`tlast` bit is set.
  - `tdata` of non-selected channels is driven 0.
  - The main register's stored dest selects which `m_axis_tready` bit drains it.
- The out-of-range check in IDLE uses the `sel` value present on the accepting edge.
- Back-to-back frames: the first beat of the next frame may be accepted on the cycle immediately after the previous `tlast` beat, with a new `sel`, and no bubble.
- Frames to different channels may coexist in main and skid; each retains its own dest.
- Non-selected channel `tready` has no effect.
- `tlast` on the slice output is carried per beat; dest is unchanged until that beat drains.
- Asserting `rst` mid-frame clears the FSM and both registers immediately; the partial frame is lost and no output `tvalid` remains.
- Widths: `sel` is compared unsigned against `channels`; no arithmetic on `tdata`.

Test Plan:
- Frame routing: width=8, channels=4. Frame of 4 beats {0x11,0x22,0x33,0x44} with `sel=2`; `sel` changed to 1 after beat 1 -> all 4 beats appear on channel 2 only, `tlast` on 0x44, first valid 1 cycle after accept, `busy=1` until the `tlast` accept.
- Back-to-back: 1-beat frame 0xA5 with `sel=0`, immediately followed by 1-beat frame 0x5A with `sel=3`, all `tready=1` -> ch0 valid cycle n, ch3 valid cycle n+1, no bubble, `s_axis_tready` stays 1.
- Backpressure/skid: stream of 5 beats to ch1; `m_axis_tready[1]=0` for cycles 2-4 -> `s_axis_tready` drops after 2 beats are held; no beat lost or duplicated; order preserved when ready returns.
- Drop: channels=3, `sel=3`, 3-beat frame -> `s_axis_tready=1` throughout, no `m_axis_tvalid` asserted, `drop_pulse` high exactly 1 cycle; next frame with `sel=0` routes normally.
- Reset mid-frame: assert `rst` after beat 2 of a 4-beat frame to ch1 -> all `m_axis_tvalid=0` and `busy=0` immediately. After release, a new frame with `sel=0` goes to ch0; stale ch1 data never appears.
